bomb_pool: RTL and testbench
============================

BOMB_POOL -- requirements
Module: bomb_pool

Interface
REQ-001 Parameter NUM_BOMBS, default 4: number of independent bomb slots (1..8).
REQ-002 Parameter FUSE_FRAMES, default 120: frames from placement to detonation.
REQ-003 Parameter BLAST_FRAMES, default 30: frames a bomb stays in blast.
REQ-004 Parameter PULSE_FRAMES, default 8: frames per size toggle while armed.
REQ-005 Parameter BLAST_RADIUS, default 64: chain-reaction reach in pixels (10-bit).
REQ-006 Reset is asynchronous and active-high; frame_clk is the clock.
REQ-007 Reset  input  1  asynchronous active-high reset.
REQ-008 frame_clk  input  1  frame-rate clock; all state changes on its rising edge.
REQ-009 place  input  1  level request to drop a bomb; acted on at its rising edge.
REQ-010 userX, userY  input  10 each  player position captured on placement.
REQ-011 detonate  input  NUM_BOMBS  per-slot forced-detonation request.
REQ-012 bomb_active  output  NUM_BOMBS  slot is ARMED or BLAST.
REQ-013 bomb_blast  output  NUM_BOMBS  slot is in BLAST.
REQ-014 bombX, bombY, bombS  output  10*NUM_BOMBS each  packed per-slot position/size; slot i occupies bits [10i+9:10i].
REQ-015 place_ack  output  1  one-frame pulse when a placement is accepted.
REQ-016 pool_full  output  1  no slot is IDLE.

Function
REQ-017 Each slot SHALL have states IDLE, ARMED and BLAST, plus a fuse/blast counter of width clog2(max(FUSE_FRAMES,BLAST_FRAMES)+1).
REQ-018 Placement is triggered when place=1 and its value registered on the previous edge was 0; holding place high SHALL NOT place again.
REQ-019 On a trigger, the lowest-index IDLE slot SHALL go ARMED, latch userX/userY, load its counter with FUSE_FRAMES, and assert place_ack for that one frame.
REQ-020 A trigger SHALL be rejected (no state change, place_ack=0) when pool_full=1 or when any non-IDLE slot already holds exactly (userX,userY).
REQ-021 Slot availability is judged on pre-edge state: a slot leaving BLAST on the same edge is not reusable until the next edge.
REQ-022 ARMED: the counter decrements each frame, and the slot goes to BLAST with counter=BLAST_FRAMES when the pre-edge counter is 1.
REQ-023 ARMED: the slot goes to BLAST on the next edge when detonate[i]=1 or on chain reaction, whichever comes first; the fuse is then abandoned.
REQ-024 Chain reaction: an ARMED slot j detonates when some slot k is in BLAST (pre-edge) and either (Xj==Xk and |Yj-Yk|<=BLAST_RADIUS) or (Yj==Yk and |Xj-Xk|<=BLAST_RADIUS).
REQ-025 Absolute differences SHALL be computed unsigned in 10 bits without wrap (larger minus smaller).
REQ-026 BLAST: the counter decrements each frame, and the slot goes to IDLE when the pre-edge counter is 1; detonate is ignored.
REQ-027 detonate on an IDLE slot SHALL be ignored.
REQ-028 bombS in ARMED starts at 4 on placement and toggles 4<->6 every PULSE_FRAMES frames.
REQ-029 bombS is 16 in BLAST and 0 in IDLE.
REQ-030 An IDLE slot SHALL present bombX=700 and bombY=500 (off-screen).
REQ-031 All outputs SHALL be registered or derived combinationally from registered state only; outputs reflect a transition immediately after the edge that causes it.
REQ-032 pool_full and bomb_active SHALL be consistent with slot states in the same frame.

Reset
REQ-033 On Reset, all slots go IDLE, counters=0, the place history register=0, place_ack=0, pool_full=0, bomb_active=0, bomb_blast=0, bombX=700, bombY=500 and bombS=0 for all slots.
REQ-034 Reset asserted mid-fuse or mid-blast SHALL abort everything; no detonation is carried over.
REQ-035 A place held high across Reset release SHALL produce a placement on the first edge after release.

Verification
REQ-036 Place at (100,200), no other stimulus -> slot0 ARMED with place_ack for 1 frame; bombS 4/6 toggling every 8 frames; BLAST after exactly 120 frames with bombS=16; IDLE 30 frames later with bombX/Y=700/500.
REQ-037 Hold place high for 10 frames -> exactly one placement; a second rising edge at the same position -> rejected.
REQ-038 Fill all 4 slots at distinct positions, then a 5th place -> pool_full=1, no ack, no state change.
REQ-039 Bombs at (100,200) and (100,250); detonate[0] -> slot0 BLAST next edge and slot1 BLAST one edge later; a bomb at (100,300) (distance 100) stays ARMED.
REQ-040 Slot0 leaves BLAST on the same edge a place arrives with slots1-3 busy -> rejected; a place on the next rising edge -> accepted into slot0.
REQ-041 Reset asserted while two bombs are ARMED and one is in BLAST -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bomb_pool.sv
// Pool of NUM_BOMBS independent bomb slots: placement, fuse countdown, size pulsing,
// blast timing and cross-shaped chain reactions between slots, all at frame rate.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | slot free, parked off-screen, size 0
//   S_ARMED | fuse counting down, size pulsing 4<->6
//   S_BLAST | exploding for BLAST_FRAMES, size 16, ignores detonate
module bomb_pool #(
  parameter int unsigned NUM_BOMBS    = 4,
  parameter int unsigned FUSE_FRAMES  = 120,
  parameter int unsigned BLAST_FRAMES = 30,
  parameter int unsigned PULSE_FRAMES = 8,
  parameter logic [9:0]  BLAST_RADIUS = 10'd64
) (
  input  logic                      Reset,
  input  logic                      frame_clk,
  input  logic                      place,
  input  logic [9:0]                userX,
  input  logic [9:0]                userY,
  input  logic [NUM_BOMBS-1:0]      detonate,
  output logic [NUM_BOMBS-1:0]      bomb_active,
  output logic [NUM_BOMBS-1:0]      bomb_blast,
  output logic [10*NUM_BOMBS-1:0]   bombX,
  output logic [10*NUM_BOMBS-1:0]   bombY,
  output logic [10*NUM_BOMBS-1:0]   bombS,
  output logic                      place_ack,
  output logic                      pool_full
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_BLAST = 2'd2;

  localparam int unsigned MAX_FRAMES = (FUSE_FRAMES > BLAST_FRAMES) ? FUSE_FRAMES : BLAST_FRAMES;
  localparam int unsigned CW = $clog2(MAX_FRAMES + 1);
  localparam int unsigned PW = $clog2(PULSE_FRAMES + 1);

  localparam logic [9:0] OFF_X = 10'd700;
  localparam logic [9:0] OFF_Y = 10'd500;

  logic [1:0]           state_q [NUM_BOMBS];
  logic [1:0]           state_d [NUM_BOMBS];
  logic [CW-1:0]        cnt_q   [NUM_BOMBS];
  logic [CW-1:0]        cnt_d   [NUM_BOMBS];
  logic [PW-1:0]        pulse_q [NUM_BOMBS];
  logic [PW-1:0]        pulse_d [NUM_BOMBS];
  logic [9:0]           x_q     [NUM_BOMBS];
  logic [9:0]           x_d     [NUM_BOMBS];
  logic [9:0]           y_q     [NUM_BOMBS];
  logic [9:0]           y_d     [NUM_BOMBS];
  logic [NUM_BOMBS-1:0] big_q, big_d;
  logic                 place_q;
  logic                 ack_q, ack_d;

  logic [NUM_BOMBS-1:0] sel, chain;
  logic                 full, dup, trigger, accept, found;

  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Everything here looks only at pre-edge state, so a slot finishing its blast
  // this edge still counts as busy and cannot be picked.
  always_comb begin
    full  = 1'b1;
    dup   = 1'b0;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      if (state_q[i] == S_IDLE) full = 1'b0;
      else if (x_q[i] == userX && y_q[i] == userY) dup = 1'b1;
    end
    trigger = place & ~place_q;
    accept  = trigger & ~full & ~dup;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      if (!found && state_q[i] == S_IDLE) begin
        sel[i] = accept;
        found  = 1'b1;
      end
    end
    for (int j = 0; j < NUM_BOMBS; j++) begin
      chain[j] = 1'b0;
      for (int k = 0; k < NUM_BOMBS; k++) begin
        if (state_q[k] == S_BLAST &&
            ((x_q[j] == x_q[k] && abs_diff(y_q[j], y_q[k]) <= BLAST_RADIUS) ||
             (y_q[j] == y_q[k] && abs_diff(x_q[j], x_q[k]) <= BLAST_RADIUS)))
          chain[j] = 1'b1;
      end
    end
  end

  always_comb begin
    big_d = big_q;
    ack_d = accept;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pulse_d[i] = pulse_q[i];
      x_d[i]     = x_q[i];
      y_d[i]     = y_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (sel[i]) begin
            state_d[i] = S_ARMED;
            cnt_d[i]   = CW'(FUSE_FRAMES);
            pulse_d[i] = PW'(PULSE_FRAMES);
            big_d[i]   = 1'b0;
            x_d[i]     = userX;
            y_d[i]     = userY;
          end
        end
        S_ARMED: begin
          if (detonate[i] || chain[i] || cnt_q[i] == CW'(1)) begin
            state_d[i] = S_BLAST;
            cnt_d[i]   = CW'(BLAST_FRAMES);
          end else begin
            cnt_d[i] = cnt_q[i] - CW'(1);
            if (pulse_q[i] == PW'(1)) begin
              pulse_d[i] = PW'(PULSE_FRAMES);
              big_d[i]   = ~big_q[i];
            end else begin
              pulse_d[i] = pulse_q[i] - PW'(1);
            end
          end
        end
        S_BLAST: begin
          if (cnt_q[i] == CW'(1)) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] - CW'(1);
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_BOMBS; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        pulse_q[i] <= '0;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
      end
      big_q   <= '0;
      place_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BOMBS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        pulse_q[i] <= pulse_d[i];
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
      end
      big_q   <= big_d;
      place_q <= place;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    bomb_active = '0;
    bomb_blast  = '0;
    bombX       = '0;
    bombY       = '0;
    bombS       = '0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      bomb_active[i] = (state_q[i] != S_IDLE);
      bomb_blast[i]  = (state_q[i] == S_BLAST);
      bombX[10*i +: 10] = (state_q[i] == S_IDLE) ? OFF_X : x_q[i];
      bombY[10*i +: 10] = (state_q[i] == S_IDLE) ? OFF_Y : y_q[i];
      case (state_q[i])
        S_ARMED: bombS[10*i +: 10] = big_q[i] ? 10'd6 : 10'd4;
        S_BLAST: bombS[10*i +: 10] = 10'd16;
        default: bombS[10*i +: 10] = 10'd0;
      endcase
    end
    place_ack = ack_q;
    pool_full = full;
  end

endmodule

// File: tb/tb_bomb_pool.sv
// Scoreboard bench for bomb_pool: expected frame snapshots are derived from the
// placement/detonation edges recorded by the bench and compared after each edge.
module tb_bomb_pool;

  localparam int N = 4;
  localparam int C_IDLE = 0, C_SMALL = 1, C_BIG = 2, C_BLAST = 3;

  logic           Reset, frame_clk, place;
  logic [9:0]     userX, userY;
  logic [N-1:0]   detonate;
  logic [N-1:0]   bomb_active, bomb_blast;
  logic [10*N-1:0] bombX, bombY, bombS;
  logic           place_ack, pool_full;

  bomb_pool #(
    .NUM_BOMBS(N), .FUSE_FRAMES(120), .BLAST_FRAMES(30),
    .PULSE_FRAMES(8), .BLAST_RADIUS(10'd64)
  ) dut (
    .Reset(Reset), .frame_clk(frame_clk), .place(place),
    .userX(userX), .userY(userY), .detonate(detonate),
    .bomb_active(bomb_active), .bomb_blast(bomb_blast),
    .bombX(bombX), .bombY(bombY), .bombS(bombS),
    .place_ack(place_ack), .pool_full(pool_full)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct packed {
    logic [N-1:0]    act;
    logic [N-1:0]    blast;
    logic            ack;
    logic            full;
    logic [10*N-1:0] x;
    logic [10*N-1:0] y;
    logic [10*N-1:0] s;
  } snap_t;

  snap_t      exp_q[$];
  snap_t      obs, ex;
  int         vec_cnt = 0;
  int         err_cnt = 0;
  int         e = 0;
  int         pl_e[N];
  int         bl_e[N];
  logic [9:0] mx[N];
  logic [9:0] my[N];

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      pl_e[i] = -1;
      bl_e[i] = -1;
      mx[i]   = '0;
      my[i]   = '0;
    end
  endfunction

  function automatic void model_place(input int i, input int ed, input logic [9:0] px, input logic [9:0] py);
    pl_e[i] = ed;
    bl_e[i] = ed + 120;
    mx[i]   = px;
    my[i]   = py;
  endfunction

  function automatic int code_at(input int i, input int ed);
    if (pl_e[i] < 0 || ed < pl_e[i]) return C_IDLE;
    if (ed >= bl_e[i]) return (ed - bl_e[i] < 30) ? C_BLAST : C_IDLE;
    return ((((ed - pl_e[i]) / 8) % 2) == 1) ? C_BIG : C_SMALL;
  endfunction

  function automatic snap_t build_exp(input int ed, input logic ack);
    snap_t s;
    int c;
    s = '0;
    s.ack  = ack;
    s.full = 1'b1;
    for (int i = 0; i < N; i++) begin
      c = code_at(i, ed);
      s.act[i]   = (c != C_IDLE);
      s.blast[i] = (c == C_BLAST);
      if (c == C_IDLE) s.full = 1'b0;
      s.x[10*i +: 10] = (c == C_IDLE) ? 10'd700 : mx[i];
      s.y[10*i +: 10] = (c == C_IDLE) ? 10'd500 : my[i];
      s.s[10*i +: 10] = (c == C_IDLE) ? 10'd0 : (c == C_BLAST) ? 10'd16 : (c == C_BIG) ? 10'd6 : 10'd4;
    end
    return s;
  endfunction

  function automatic snap_t snap_now();
    snap_t s;
    s.act   = bomb_active;
    s.blast = bomb_blast;
    s.ack   = place_ack;
    s.full  = pool_full;
    s.x     = bombX;
    s.y     = bombY;
    s.s     = bombS;
    return s;
  endfunction

  task automatic step();
    @(posedge frame_clk);
    e++;
    @(negedge frame_clk);
  endtask

  task automatic do_reset();
    Reset = 1'b1; place = 1'b0; detonate = '0;
    step();
    Reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    Reset = 1'b1; place = 1'b0; detonate = '0; userX = '0; userY = '0;
    model_clear();
    #2;
    exp_q.push_back(build_exp(e, 1'b0));
    ex = exp_q.pop_front(); obs = snap_now(); vec_cnt++;
    if (obs !== ex) begin
      err_cnt++;
      $display("FAIL reset_state: got act=%b blast=%b ack=%b full=%b X=%h Y=%h S=%h, need act=%b blast=%b ack=%b full=%b X=%h Y=%h S=%h",
               obs.act, obs.blast, obs.ack, obs.full, obs.x, obs.y, obs.s, ex.act, ex.blast, ex.ack, ex.full, ex.x, ex.y, ex.s);
    end
    step();
    Reset = 1'b0;
    for (int f = 0; f < 3; f++) begin
      detonate = 4'hF;
      exp_q.push_back(build_exp(e + 1, 1'b0));
      step();
      ex = exp_q.pop_front(); obs = snap_now(); vec_cnt++;
      if (obs !== ex) begin
        err_cnt++;
        $display("FAIL idle_detonate f=%0d: got act=%b blast=%b ack=%b S=%h, need act=%b blast=%b ack=%b S=%h",
                 f, obs.act, obs.blast, obs.ack, obs.s, ex.act, ex.blast, ex.ack, ex.s);
      end
    end
    detonate = '0;
  endtask

  task automatic test_lifecycle();
    logic ack;
    for (int t = 0; t <= 150; t++) begin
      ack = 1'b0;
      place = (t == 0);
      if (t == 0) begin
        userX = 10'd100; userY = 10'd200;
        model_place(0, e + 1, 10'd100, 10'd200);
        ack = 1'b1;
      end
      exp_q.push_back(build_exp(e + 1, ack));
      step();
      ex = exp_q.pop_front(); obs = snap_now(); vec_cnt++;
      if (obs !== ex) begin
        err_cnt++;
        $display("FAIL lifecycle t=%0d: got act=%b blast=%b ack=%b X=%h Y=%h S=%h, need act=%b blast=%b ack=%b X=%h Y=%h S=%h",
                 t, obs.act, obs.blast, obs.ack, obs.x, obs.y, obs.s, ex.act, ex.blast, ex.ack, ex.x, ex.y, ex.s);
      end
    end
    place = 1'b0;
  endtask

  task automatic test_hold_dup();
    logic ack;
    userX = 10'd300; userY = 10'd300;
    for (int t = 0; t < 12; t++) begin
      ack = 1'b0;
      place = (t != 10);
      if (t == 0) begin
        model_place(0, e + 1, 10'd300, 10'd300);
        ack = 1'b1;
      end
      exp_q.push_back(build_exp(e + 1, ack));
      step();
      ex = exp_q.pop_front(); obs = snap_now(); vec_cnt++;
      if (obs !== ex) begin
        err_cnt++;
        $display("FAIL hold_dup t=%0d: got act=%b ack=%b full=%b S=%h, need act=%b ack=%b full=%b S=%h",
                 t, obs.act, obs.ack, obs.full, obs.s, ex.act, ex.ack, ex.full, ex.s);
      end
    end
    do_reset();
  endtask

  task automatic test_pool_full();
    logic ack;
    for (int f = 0; f < 10; f++) begin
      ack = 1'b0;
      place = (f % 2 == 0);
      if (f % 2 == 0) begin
        userX = 10'(10 * (f / 2 + 1));
        userY = 10'(10 * (f / 2 + 1));
        if (f < 8) begin
          model_place(f / 2, e + 1, userX, userY);
          ack = 1'b1;
        end
      end
      exp_q.push_back(build_exp(e + 1, ack));
      step();
      ex = exp_q.pop_front(); obs = snap_now(); vec_cnt++;
      if (obs !== ex) begin
        err_cnt++;
        $display("FAIL pool_full f=%0d: got act=%b ack=%b full=%b X=%h S=%h, need act=%b ack=%b full=%b X=%h S=%h",
                 f, obs.act, obs.ack, obs.full, obs.x, obs.s, ex.act, ex.ack, ex.full, ex.x, ex.s);
      end
    end
    do_reset();
  endtask

  task automatic test_chain();
    logic [9:0] ax[2]   = '{10'd100, 10'd100};
    logic [9:0] ay[2]   = '{10'd200, 10'd250};
    logic [9:0] bx[N]   = '{10'd100, 10'd100, 10'd164, 10'd100};
    logic [9:0] by[N]   = '{10'd200, 10'd300, 10'd200, 10'd265};
    logic ack;
    // Two bombs 50 apart on the same column: slot1 follows slot0 by one frame.
    for (int f = 0; f < 37; f++) begin
      ack = 1'b0; place = 1'b0; detonate = '0;
      if (f < 4 && f % 2 == 0) begin
        place = 1'b1; userX = ax[f / 2]; userY = ay[f / 2];
        model_place(f / 2, e + 1, userX, userY);
        ack = 1'b1;
      end
      if (f == 4) begin
        bl_e[0] = e + 1;
        bl_e[1] = e + 2;
      end
      if (f == 4 || f == 5) detonate = 4'b0001;
      exp_q.push_back(build_exp(e + 1, ack));
      step();
      ex = exp_q.pop_front(); obs = snap_now(); vec_cnt++;
      if (obs !== ex) begin
        err_cnt++;
        $display("FAIL chain_near f=%0d: got act=%b blast=%b ack=%b S=%h, need act=%b blast=%b ack=%b S=%h",
                 f, obs.act, obs.blast, obs.ack, obs.s, ex.act, ex.blast, ex.ack, ex.s);
      end
    end
    do_reset();
    // Exactly 64 apart chains; 65 and 100 apart stay armed.
    for (int f = 0; f < 42; f++) begin
      ack = 1'b0; place = 1'b0; detonate = '0;
      if (f < 8 && f % 2 == 0) begin
        place = 1'b1; userX = bx[f / 2]; userY = by[f / 2];
        model_place(f / 2, e + 1, userX, userY);
        ack = 1'b1;
      end
      if (f == 8) begin
        bl_e[0] = e + 1;
        bl_e[2] = e + 2;
      end
      if (f >= 8 && f < 11) detonate = 4'b0001;
      exp_q.push_back(build_exp(e + 1, ack));
      step();
      ex = exp_q.pop_front(); obs = snap_now(); vec_cnt++;
      if (obs !== ex) begin
        err_cnt++;
        $display("FAIL chain_radius f=%0d: got act=%b blast=%b ack=%b S=%h, need act=%b blast=%b ack=%b S=%h",
                 f, obs.act, obs.blast, obs.ack, obs.s, ex.act, ex.blast, ex.ack, ex.s);
      end
    end
    do_reset();
  endtask

  task automatic test_slot_reuse();
    logic ack;
    for (int f = 0; f < 36; f++) begin
      ack = 1'b0; place = 1'b0; detonate = '0;
      if (f < 8 && f % 2 == 0) begin
        place = 1'b1;
        userX = 10'(10 * (f / 2 + 1)); userY = userX;
        model_place(f / 2, e + 1, userX, userY);
        ack = 1'b1;
      end
      if (f == 1) begin
        detonate = 4'b0001;
        bl_e[0] = e + 1;
      end
      if (f == 31 || f == 33) begin
        place = 1'b1; userX = 10'd50; userY = 10'd50;
      end
      if (f == 33) begin
        model_place(0, e + 1, 10'd50, 10'd50);
        ack = 1'b1;
      end
      exp_q.push_back(build_exp(e + 1, ack));
      step();
      ex = exp_q.pop_front(); obs = snap_now(); vec_cnt++;
      if (obs !== ex) begin
        err_cnt++;
        $display("FAIL slot_reuse f=%0d: got act=%b blast=%b ack=%b full=%b X=%h, need act=%b blast=%b ack=%b full=%b X=%h",
                 f, obs.act, obs.blast, obs.ack, obs.full, obs.x, ex.act, ex.blast, ex.ack, ex.full, ex.x);
      end
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    logic ack;
    for (int f = 0; f < 7; f++) begin
      ack = 1'b0; place = 1'b0; detonate = '0;
      if (f < 6 && f % 2 == 0) begin
        place = 1'b1;
        userX = 10'(10 * (f / 2 + 1)); userY = userX;
        model_place(f / 2, e + 1, userX, userY);
        ack = 1'b1;
      end
      if (f == 5) begin
        detonate = 4'b0001;
        bl_e[0] = e + 1;
      end
      exp_q.push_back(build_exp(e + 1, ack));
      step();
      ex = exp_q.pop_front(); obs = snap_now(); vec_cnt++;
      if (obs !== ex) begin
        err_cnt++;
        $display("FAIL reset_mid_setup f=%0d: got act=%b blast=%b ack=%b, need act=%b blast=%b ack=%b",
                 f, obs.act, obs.blast, obs.ack, ex.act, ex.blast, ex.ack);
      end
    end
    // Assert between edges; outputs must clear before the next clock.
    place = 1'b1; userX = 10'd77; userY = 10'd88;
    Reset = 1'b1;
    model_clear();
    exp_q.push_back(build_exp(e, 1'b0));
    #2;
    ex = exp_q.pop_front(); obs = snap_now(); vec_cnt++;
    if (obs !== ex) begin
      err_cnt++;
      $display("FAIL reset_async: got act=%b blast=%b ack=%b full=%b X=%h S=%h, need act=%b blast=%b ack=%b full=%b X=%h S=%h",
               obs.act, obs.blast, obs.ack, obs.full, obs.x, obs.s, ex.act, ex.blast, ex.ack, ex.full, ex.x, ex.s);
    end
    for (int f = 0; f < 2; f++) begin
      ack = 1'b0;
      if (f == 1) begin
        Reset = 1'b0;
        model_place(0, e + 1, 10'd77, 10'd88);
        ack = 1'b1;
      end
      exp_q.push_back(build_exp(e + 1, ack));
      step();
      ex = exp_q.pop_front(); obs = snap_now(); vec_cnt++;
      if (obs !== ex) begin
        err_cnt++;
        $display("FAIL place_across_reset f=%0d: got act=%b ack=%b X=%h Y=%h, need act=%b ack=%b X=%h Y=%h",
                 f, obs.act, obs.ack, obs.x, obs.y, ex.act, ex.ack, ex.x, ex.y);
      end
    end
    place = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lifecycle();
    test_hold_dup();
    test_pool_full();
    test_chain();
    test_slot_reuse();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vec_cnt);
    $fatal(1, "watchdog");
  end

endmodule
